// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, state encoding
// and the datapath select codes driven onto ALUOp, ALUSrcB and PCSource.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the last cycle allowed before the
// controller gives up on a stalled access.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturating at the limit keeps the counter from wrapping if the FSM lingers.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller sequencing the shared multicycle MIPS datapath, with
// handshaked memory accesses, a stall timeout and a retired-instruction count.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Trap,
  output logic [CNT_W-1:0] RetiredCnt
);

  state_t state;
  logic   in_wait;
  logic   expired;
  logic   unused_zero;

  // The branch decision is taken by the datapath from PCWriteCond and Zero.
  assign unused_zero = Zero;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // Leaving a wait state always coincides with MemReady, so clearing then
  // guarantees a fresh count on every entry.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (Clk),
    .clear   (Rst || !in_wait || MemReady),
    .enable  (in_wait && !MemReady),
    .expired (expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_FETCH;
      RetiredCnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (MemReady)     state <= S_DECODE;
          else if (expired) state <= S_TRAP;
        end
        S_DECODE: begin
          case (Opcode)
            OP_RTYPE:     state <= S_R_EXEC;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDI_EXEC;
            default:      state <= S_TRAP;
          endcase
        end
        S_MEM_ADDR: begin
          if (Opcode == OP_LW)      state <= S_MEM_RD;
          else if (Opcode == OP_SW) state <= S_MEM_WR;
          else                      state <= S_TRAP;
        end
        S_MEM_RD: begin
          if (MemReady)     state <= S_MEM_WB;
          else if (expired) state <= S_TRAP;
        end
        S_MEM_WR: begin
          if (MemReady) begin
            state      <= S_FETCH;
            RetiredCnt <= RetiredCnt + CNT_W'(1);
          end else if (expired) begin
            state <= S_TRAP;
          end
        end
        S_R_EXEC:    state <= S_R_WB;
        S_ADDI_EXEC: state <= S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
          state      <= S_FETCH;
          RetiredCnt <= RetiredCnt + CNT_W'(1);
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase
    // Reset must silence every strobe even mid-access.
    if (Rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign State = state;
  assign Trap  = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level driver with an output-vector
// scoreboard checked every cycle by an independent monitor.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int W       = 53;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegDst, RegWrite, ALUSrcA, Trap;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic [31:0] RetiredCnt;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Opcode      (Opcode),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .Trap        (Trap),
    .RetiredCnt  (RetiredCnt)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [31:0]  retired_m = '0;
  logic [W-1:0] exp_v, act_v;

  // Control word each state should present, read from the state table.
  function automatic logic [W-1:0] expect_vec(input int st, input bit mr, input bit rst_i,
                                              input logic [31:0] cnt);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, trp;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, trp} = '0;
    srcb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      0:  begin mrd = 1; srcb = 2'd1; pcw = mr; irw = mr; end
      1:  srcb = 2'd3;
      2:  begin srca = 1; srcb = 2'd2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin srca = 1; aop = 2'd2; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin srca = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
      9:  begin pcw = 1; pcs = 2'd2; end
      10: begin srca = 1; srcb = 2'd2; end
      11: rw = 1;
      12: trp = 1;
      default: ;
    endcase
    if (rst_i) {pcw, pcwc, mrd, mwr, irw, rw} = '0;
    return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aop, pcs, trp, cnt};
  endfunction

  // monitor
  always @(negedge Clk) begin
    cyc++;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               Trap, RetiredCnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL ctrl_word cycle %0d: actual state=%0d word=%h required state=%0d word=%h",
                 cyc, act_v[W-1 -: 4], act_v, exp_v[W-1 -: 4], exp_v);
      end
    end
  end

  // driver tasks
  task automatic junk();
    Opcode = 6'($urandom);
    Zero   = 1'($urandom_range(0, 1));
  endtask

  task automatic step(input int st, input bit mr, input bit rst_i);
    MemReady = mr;
    Rst      = rst_i;
    exp_q.push_back(expect_vec(st, mr, rst_i, retired_m));
    @(posedge Clk);
    #1;
  endtask

  task automatic rnd_step(input int st);
    step(st, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic wait_state(input int st, input int waits);
    for (int i = 0; i < waits; i++) begin
      junk();
      step(st, 1'b0, 1'b0);
    end
    junk();
    step(st, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int st);
    junk();
    step(st, 1'($urandom_range(0, 1)), 1'b1);
    retired_m = '0;
  endtask

  // One instruction from fetch to retirement; an illegal opcode stops at DECODE.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    wait_state(0, fw);
    Opcode = op;
    Zero   = 1'($urandom_range(0, 1));
    rnd_step(1);
    case (op)
      OP_R:    begin junk(); rnd_step(6); junk(); rnd_step(7); retired_m++; end
      OP_LW:   begin Opcode = op; rnd_step(2); wait_state(3, mw); junk(); rnd_step(4); retired_m++; end
      OP_SW:   begin Opcode = op; rnd_step(2); wait_state(5, mw); retired_m++; end
      OP_BEQ:  begin junk(); rnd_step(8); retired_m++; end
      OP_JMP:  begin junk(); rnd_step(9); retired_m++; end
      OP_ADDI: begin junk(); rnd_step(10); junk(); rnd_step(11); retired_m++; end
      default: ;
    endcase
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_ADDI};
    Rst = 1'b1; MemReady = 1'b1; Opcode = '0; Zero = 1'b0;
    @(posedge Clk);
    #1;
    step(0, 1'b1, 1'b1);

    // R-type then lw with a stalled read, then beq taken and not taken
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    Zero = 1'b1;
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BEQ, 0, 0);

    // illegal opcode traps and holds until reset
    run_instr(6'h3F, 0, 0);
    for (int i = 0; i < 20; i++) begin junk(); rnd_step(12); end
    do_reset(12);

    // fetch timeout, then completion on the last allowed cycle
    for (int i = 0; i < TIMEOUT; i++) begin junk(); step(0, 1'b0, 1'b0); end
    for (int i = 0; i < 3; i++) begin junk(); rnd_step(12); end
    do_reset(12);
    run_instr(OP_JMP, TIMEOUT - 1, 0);

    // read timeout in MEM_RD, then a write completing at the limit
    wait_state(0, 0);
    Opcode = OP_LW; rnd_step(1); rnd_step(2);
    for (int i = 0; i < TIMEOUT; i++) begin junk(); step(3, 1'b0, 1'b0); end
    junk(); rnd_step(12);
    do_reset(12);
    run_instr(OP_SW, 0, TIMEOUT - 1);
    run_instr(OP_ADDI, 1, 0);

    // reset in the middle of a write
    wait_state(0, 0);
    Opcode = OP_SW; rnd_step(1); rnd_step(2);
    junk(); step(5, 1'b0, 1'b0);
    do_reset(5);

    // random instruction mix with random memory latency
    for (int n = 0; n < 60; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, TIMEOUT - 1));
    end
    junk();
    step(0, 1'b0, 1'b0);

    @(posedge Clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
